// File: rtl/ssd1306_pkg.sv
// Shared SSD1306 definitions: opcodes, decoder states, panel geometry and the
// init sequence emitted by the screen driver.
package ssd1306_pkg;

    localparam int DEF_NUM_COLS  = 128;
    localparam int DEF_NUM_PAGES = 8;

    localparam logic [7:0] CMD_ADDR_MODE     = 8'h20;
    localparam logic [7:0] CMD_COL_ADDR      = 8'h21;
    localparam logic [7:0] CMD_PAGE_ADDR     = 8'h22;
    localparam logic [7:0] CMD_START_LINE    = 8'h40;
    localparam logic [7:0] CMD_SET_CONTRAST  = 8'h81;
    localparam logic [7:0] CMD_CHARGE_PUMP   = 8'h8D;
    localparam logic [7:0] CMD_SEG_REMAP     = 8'hA1;
    localparam logic [7:0] CMD_RESUME_RAM    = 8'hA4;
    localparam logic [7:0] CMD_NORMAL        = 8'hA6;
    localparam logic [7:0] CMD_INVERT        = 8'hA7;
    localparam logic [7:0] CMD_SET_MUX       = 8'hA8;
    localparam logic [7:0] CMD_DISPLAY_OFF   = 8'hAE;
    localparam logic [7:0] CMD_DISPLAY_ON    = 8'hAF;
    localparam logic [7:0] CMD_COM_SCAN_DEC  = 8'hC8;
    localparam logic [7:0] CMD_SET_OFFSET    = 8'hD3;
    localparam logic [7:0] CMD_SET_CLK_DIV   = 8'hD5;
    localparam logic [7:0] CMD_PRECHARGE     = 8'hD9;
    localparam logic [7:0] CMD_COM_PINS      = 8'hDA;
    localparam logic [7:0] CMD_VCOMH         = 8'hDB;

    typedef enum logic [1:0] {
        CMD_IDLE,
        CMD_PARAM1,
        CMD_PARAM2
    } cmd_state_e;

    localparam int INIT_LEN = 25;
    localparam logic [7:0] INIT_SEQ [INIT_LEN] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
        8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
        8'h81, 8'h7F, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6,
        8'hAF
    };

    function automatic logic takes_param(input logic [7:0] op);
        case (op)
            CMD_SET_CLK_DIV, CMD_SET_MUX, CMD_SET_OFFSET, CMD_CHARGE_PUMP,
            CMD_ADDR_MODE, CMD_COM_PINS, CMD_SET_CONTRAST, CMD_PRECHARGE,
            CMD_VCOMH, CMD_COL_ADDR, CMD_PAGE_ADDR: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ssd1306_spi_receiver_if.sv
// SSD1306 panel pins plus the framebuffer write port; the driver side is the
// master, the panel-side receiver is the slave.
interface ssd1306_spi_receiver_if;
    logic       ioReset;
    logic       ioCs;
    logic       ioSclk;
    logic       ioSdin;
    logic       ioDc;
    logic       fbWrEn;
    logic [9:0] fbWrAddr;
    logic [7:0] fbWrData;

    modport master (
        output ioReset, ioCs, ioSclk, ioSdin, ioDc,
        input  fbWrEn, fbWrAddr, fbWrData
    );

    modport slave (
        input  ioReset, ioCs, ioSclk, ioSdin, ioDc,
        output fbWrEn, fbWrAddr, fbWrData
    );
endinterface

// File: rtl/ssd1306_spi_receiver_deser.sv
// Synchronises the panel pins and turns SCLK rising edges into whole bytes;
// a CS rise drops any partial byte.
module spi_byte_deserializer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pin_reset,
    input  logic       pin_cs,
    input  logic       pin_sclk,
    input  logic       pin_sdin,
    input  logic       pin_dc,
    output logic       panel_reset,
    output logic       byteValid,
    output logic [7:0] byteData,
    output logic       byteDc
);

    // Bit order {reset, cs, sclk, sdin, dc}; idle is reset released, CS high.
    localparam logic [4:0] PIN_IDLE = 5'b11000;

    logic [4:0] sync_q [SYNC_STAGES];
    logic [4:0] pins;
    logic       cs_s, sclk_s, sdin_s, dc_s;
    logic       sclk_prev, cs_prev;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic       sclk_rise, cs_rise;

    // NOTE: every flop here uses <=, so each stage samples the previous stage's old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= PIN_IDLE;
        end else begin
            sync_q[0] <= {pin_reset, pin_cs, pin_sclk, pin_sdin, pin_dc};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign pins        = sync_q[SYNC_STAGES-1];
    assign panel_reset = ~pins[4];
    assign cs_s        = pins[3];
    assign sclk_s      = pins[2];
    assign sdin_s      = pins[1];
    assign dc_s        = pins[0];

    // Gating on the previous CS sample lets a byte finish in the cycle CS rises.
    assign sclk_rise = sclk_s & ~sclk_prev & ~cs_prev;
    assign cs_rise   = cs_s & ~cs_prev;

    assign byteValid = sclk_rise & (bit_cnt == 3'd7) & ~panel_reset;
    assign byteData  = {shift_reg[6:0], sdin_s};
    assign byteDc    = dc_s;

    always_ff @(posedge clk) begin
        if (rst || panel_reset) begin
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
            bit_cnt   <= 3'd0;
            shift_reg <= 8'h00;
        end else begin
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
            if (sclk_rise) shift_reg <= byteData;
            if (cs_rise)        bit_cnt <= 3'd0;
            else if (sclk_rise) bit_cnt <= bit_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/ssd1306_spi_receiver.sv
// Panel-side SSD1306 SPI receiver: decodes the init command set and streams
// pixel bytes into a horizontally addressed framebuffer write port.
module ssd1306_spi_receiver
    import ssd1306_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_COLS    = DEF_NUM_COLS,
    parameter int NUM_PAGES   = DEF_NUM_PAGES
) (
    input  logic                  clk,
    input  logic                  rst,
    ssd1306_spi_receiver_if.slave bus,
    output logic                  displayOn,
    output logic [7:0]            contrast,
    output logic                  invert,
    output logic                  protoErr
);

    localparam logic [6:0] COL_END_INIT  = 7'(NUM_COLS - 1);
    localparam logic [2:0] PAGE_END_INIT = 3'(NUM_PAGES - 1);

    logic       panel_reset, byte_valid, byte_dc;
    logic [7:0] byte_data;

    cmd_state_e state;
    logic [7:0] opcode;
    logic [6:0] col, col_start, col_end;
    logic [2:0] page, page_start, page_end;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;

    spi_byte_deserializer #(.SYNC_STAGES(SYNC_STAGES)) u_deser (
        .clk         (clk),
        .rst         (rst),
        .pin_reset   (bus.ioReset),
        .pin_cs      (bus.ioCs),
        .pin_sclk    (bus.ioSclk),
        .pin_sdin    (bus.ioSdin),
        .pin_dc      (bus.ioDc),
        .panel_reset (panel_reset),
        .byteValid   (byte_valid),
        .byteData    (byte_data),
        .byteDc      (byte_dc)
    );

    assign bus.fbWrEn   = wr_en;
    assign bus.fbWrAddr = wr_addr;
    assign bus.fbWrData = wr_data;

    always_ff @(posedge clk) begin
        if (rst || panel_reset) begin
            state      <= CMD_IDLE;
            opcode     <= 8'h00;
            col        <= 7'd0;
            page       <= 3'd0;
            col_start  <= 7'd0;
            col_end    <= COL_END_INIT;
            page_start <= 3'd0;
            page_end   <= PAGE_END_INIT;
            wr_en      <= 1'b0;
            wr_addr    <= 10'd0;
            wr_data    <= 8'h00;
            displayOn  <= 1'b0;
            contrast   <= 8'h7F;
            invert     <= 1'b0;
            protoErr   <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low each cycle; a later assignment in this block wins.
            wr_en    <= 1'b0;
            protoErr <= 1'b0;
            if (byte_valid && byte_dc) begin
                if (state != CMD_IDLE) begin
                    protoErr <= 1'b1;
                    state    <= CMD_IDLE;
                end
                wr_en   <= 1'b1;
                wr_addr <= {page, col};
                wr_data <= byte_data;
                if (col == col_end) begin
                    col  <= col_start;
                    page <= (page == page_end) ? page_start : page + 3'd1;
                end else begin
                    col <= col + 7'd1;
                end
            end else if (byte_valid) begin
                case (state)
                    CMD_IDLE: begin
                        opcode <= byte_data;
                        if (takes_param(byte_data)) begin
                            state <= CMD_PARAM1;
                        end else begin
                            case (byte_data)
                                CMD_DISPLAY_OFF: displayOn <= 1'b0;
                                CMD_DISPLAY_ON:  displayOn <= 1'b1;
                                CMD_NORMAL:      invert    <= 1'b0;
                                CMD_INVERT:      invert    <= 1'b1;
                                default:         ;  // 40/A1/C8/A4 change nothing captured here
                            endcase
                        end
                    end
                    CMD_PARAM1: begin
                        state <= CMD_IDLE;
                        case (opcode)
                            CMD_SET_CONTRAST: contrast <= byte_data;
                            CMD_COL_ADDR: begin
                                col_start <= byte_data[6:0];
                                state     <= CMD_PARAM2;
                            end
                            CMD_PAGE_ADDR: begin
                                page_start <= byte_data[2:0];
                                state      <= CMD_PARAM2;
                            end
                            CMD_ADDR_MODE: if (byte_data != 8'h00) protoErr <= 1'b1;
                            default: ;
                        endcase
                    end
                    CMD_PARAM2: begin
                        state <= CMD_IDLE;
                        if (opcode == CMD_COL_ADDR) begin
                            col_end <= byte_data[6:0];
                            col     <= col_start;
                        end else if (opcode == CMD_PAGE_ADDR) begin
                            page_end <= byte_data[2:0];
                            page     <= page_start;
                        end
                    end
                    default: state <= CMD_IDLE;
                endcase
            end
        end
    end

endmodule
